// File: rtl/disp_mem_arbiter_pkg.sv
// Shared display-memory types and sizing for the text display path.
package disp_mem_arbiter_pkg;

  localparam int DISPADDR_W      = 12;
  localparam int DISPDATA_W      = 16;
  localparam int FONT_WIDTH      = 8;
  localparam int CHARS_WIDE      = 80;
  // Host pending this long without a grant is reported as starved.
  localparam int HOST_WAIT_LIMIT = 2 * FONT_WIDTH;

  typedef logic [DISPADDR_W-1:0] disp_addr_t;
  typedef logic [DISPDATA_W-1:0] disp_data_t;

  // Arbiter state encoding; constants live in the arbiter itself.
  typedef logic [1:0] arb_state_t;

endpackage

// File: rtl/disp_mem_arbiter_if.sv
// Bundle of video-fetch, host and RAM signals around the display memory arbiter.
// slave  : the arbiter's view (takes requests and RAM data, drives RAM controls).
// master : the surrounding system (renderer, host bridge and RAM).
interface disp_mem_arbiter_if;
  import disp_mem_arbiter_pkg::*;

  // video tile fetch
  logic       vid_rd_en;
  disp_addr_t vid_addr;
  logic       vid_data_valid;
  disp_data_t vid_data;

  // host port
  logic       host_req;
  logic       host_wr;
  disp_addr_t host_addr;
  disp_data_t host_wr_data;
  logic       host_ack;
  disp_data_t host_rd_data;
  logic       host_starved;

  // single-port RAM
  logic       mem_en;
  logic       mem_wr;
  disp_addr_t mem_addr;
  disp_data_t mem_wr_data;
  disp_data_t mem_rd_data;

  modport slave (
    input  vid_rd_en, vid_addr,
    input  host_req, host_wr, host_addr, host_wr_data,
    input  mem_rd_data,
    output vid_data_valid, vid_data,
    output host_ack, host_rd_data, host_starved,
    output mem_en, mem_wr, mem_addr, mem_wr_data
  );

  modport master (
    output vid_rd_en, vid_addr,
    output host_req, host_wr, host_addr, host_wr_data,
    output mem_rd_data,
    input  vid_data_valid, vid_data,
    input  host_ack, host_rd_data, host_starved,
    input  mem_en, mem_wr, mem_addr, mem_wr_data
  );

endinterface

// File: rtl/disp_mem_arbiter.sv
// Display memory arbiter: video fetches own the RAM whenever they strobe,
// host read/write requests fill the remaining cycles via a req/ack handshake.
module disp_mem_arbiter
  import disp_mem_arbiter_pkg::*;
#(
  parameter int WAIT_LIMIT = HOST_WAIT_LIMIT
) (
  input  logic               clk,
  input  logic               reset,
  disp_mem_arbiter_if.slave  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_WAIT = 2'd1;
  localparam logic [1:0] ACK     = 2'd2;

  localparam int             CNT_W   = $clog2(WAIT_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_LIMIT);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             starved_q, starved_d;
  logic             ack_q, ack_d;
  disp_data_t       rd_data_q, rd_data_d;
  logic             vid_vld_q;

  logic grant;
  logic blocked;

  // Host wins the RAM only in an idle cycle with no video fetch; reset
  // suppresses the grant so no host write can slip out while held in reset.
  assign grant   = (state_q == IDLE) && bus.host_req && !bus.vid_rd_en && !reset;
  assign blocked = (state_q == IDLE) && bus.host_req &&  bus.vid_rd_en;

  // RAM port mux: video first, then granted host, otherwise parked on host_addr.
  always_comb begin
    bus.mem_en   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.mem_addr = bus.host_addr;
    if (bus.vid_rd_en) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.vid_addr;
    end else if (grant) begin
      bus.mem_en   = 1'b1;
      bus.mem_wr   = bus.host_wr;
    end
  end

  assign bus.mem_wr_data = bus.host_wr_data;
  assign bus.vid_data    = bus.mem_rd_data;

  // Host FSM: writes finish at grant, reads need one extra cycle for RAM latency.
  // A video fetch during RD_WAIT is harmless: it only changes RAM output next cycle.
  always_comb begin
    state_d   = state_q;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: begin
        if (grant) state_d = bus.host_wr ? ACK : RD_WAIT;
      end
      RD_WAIT: begin
        rd_data_d = bus.mem_rd_data;
        state_d   = ACK;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ack is registered and high exactly for the cycle spent in ACK.
  assign ack_d = (state_d == ACK);

  // Count cycles the host is held off by video; clear on grant, saturate at limit.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (grant)
      wait_cnt_d = '0;
    else if (blocked && (wait_cnt_q != CNT_MAX))
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  // Sticky starvation flag, set on the same edge the counter reaches the limit.
  assign starved_d = starved_q | (wait_cnt_d == CNT_MAX);

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      wait_cnt_q <= '0;
      starved_q  <= 1'b0;
      ack_q      <= 1'b0;
      rd_data_q  <= '0;
      vid_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      starved_q  <= starved_d;
      ack_q      <= ack_d;
      rd_data_q  <= rd_data_d;
      vid_vld_q  <= bus.vid_rd_en;
    end
  end

  assign bus.vid_data_valid = vid_vld_q;
  assign bus.host_ack       = ack_q;
  assign bus.host_rd_data   = rd_data_q;
  assign bus.host_starved   = starved_q;

endmodule

// File: tb/tb_disp_mem_arbiter.sv
// Self-checking bench for disp_mem_arbiter: per-cycle vector table for the
// basic write/read/collision timing, plus sequences for scanline stress,
// reset mid-read and host starvation.
module tb_disp_mem_arbiter;
  import disp_mem_arbiter_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_fail;
  bit   vid_done;

  disp_mem_arbiter_if bus();

  disp_mem_arbiter #(.WAIT_LIMIT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM, 1-cycle read latency.
  disp_data_t ram    [4096];
  disp_data_t shadow [4096];

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wr_data;
      bus.mem_rd_data <= ram[bus.mem_addr];
    end
  end

  function automatic disp_data_t pat(input disp_addr_t a);
    return {a[3:0], a} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Issue one host op and wait (bounded) for its ack; req is left high.
  task automatic host_op(input logic w, input disp_addr_t a, input disp_data_t d,
                         output logic ok);
    @(posedge clk); #1;
    bus.host_req     = 1'b1;
    bus.host_wr      = w;
    bus.host_addr    = a;
    bus.host_wr_data = d;
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      @(negedge clk);
      if (bus.host_ack === 1'b1) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL host_ack timeout addr %h: got no ack, expected ack within 40 cycles", a);
    end
  endtask

  task automatic host_idle();
    @(posedge clk); #1;
    bus.host_req = 1'b0;
  endtask

  typedef struct {
    logic       vid;
    disp_addr_t vaddr;
    logic       req;
    logic       wr;
    disp_addr_t haddr;
    disp_data_t wdata;
    logic       e_en;
    logic       e_wr;
    disp_addr_t e_addr;
    logic       e_ack;
    logic       e_vdv;
    disp_data_t e_vdata;
    disp_data_t e_rd;
  } vec_t;

  vec_t vt [18];

  initial begin
    #200000;
    $display("FAIL watchdog: got time limit, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ok;
    n_chk = 0;
    n_fail = 0;
    vid_done = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      ram[i]    = pat(disp_addr_t'(i));
      shadow[i] = pat(disp_addr_t'(i));
    end
    ram[12'h456] = 16'h1F41;
    ram[12'h010] = 16'h0BEE;
    ram[12'h020] = 16'h2222;

    //          vid   vaddr    req   wr    haddr    wdata      en    wr    addr     ack   vdv   vdata      rd
    vt[0]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h123, 16'hA5C3, 1'b1, 1'b1, 12'h123, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vt[1]  = '{1'b0, 12'h000, 1'b1, 1'b1, 12'h123, 16'hA5C3, 1'b0, 1'b0, 12'h123, 1'b1, 1'b0, 16'h0000, 16'h0000};
    vt[2]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h123, 16'h0000, 1'b0, 1'b0, 12'h123, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vt[3]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h456, 16'h0000, 1'b1, 1'b0, 12'h456, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vt[4]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h456, 16'h0000, 1'b0, 1'b0, 12'h456, 1'b0, 1'b0, 16'h0000, 16'h0000};
    vt[5]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h456, 16'h0000, 1'b0, 1'b0, 12'h456, 1'b1, 1'b0, 16'h0000, 16'h1F41};
    vt[6]  = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h456, 16'h0000, 1'b0, 1'b0, 12'h456, 1'b0, 1'b0, 16'h0000, 16'h1F41};
    vt[7]  = '{1'b1, 12'h010, 1'b1, 1'b0, 12'h020, 16'h0000, 1'b1, 1'b0, 12'h010, 1'b0, 1'b0, 16'h0000, 16'h1F41};
    vt[8]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 16'h0000, 1'b1, 1'b0, 12'h020, 1'b0, 1'b1, 16'h0BEE, 16'h1F41};
    vt[9]  = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b0, 12'h020, 1'b0, 1'b0, 16'h0000, 16'h1F41};
    vt[10] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b0, 12'h020, 1'b1, 1'b0, 16'h0000, 16'h2222};
    vt[11] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b0, 12'h020, 1'b0, 1'b0, 16'h0000, 16'h2222};
    vt[12] = '{1'b1, 12'h123, 1'b0, 1'b0, 12'h020, 16'h0000, 1'b1, 1'b0, 12'h123, 1'b0, 1'b0, 16'h0000, 16'h2222};
    vt[13] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h020, 16'h0000, 1'b0, 1'b0, 12'h020, 1'b0, 1'b1, 16'hA5C3, 16'h2222};
    vt[14] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h456, 16'h0000, 1'b1, 1'b0, 12'h456, 1'b0, 1'b0, 16'h0000, 16'h2222};
    vt[15] = '{1'b1, 12'h010, 1'b1, 1'b0, 12'h456, 16'h0000, 1'b1, 1'b0, 12'h010, 1'b0, 1'b0, 16'h0000, 16'h2222};
    vt[16] = '{1'b0, 12'h000, 1'b1, 1'b0, 12'h456, 16'h0000, 1'b0, 1'b0, 12'h456, 1'b1, 1'b1, 16'h0BEE, 16'h1F41};
    vt[17] = '{1'b0, 12'h000, 1'b0, 1'b0, 12'h456, 16'h0000, 1'b0, 1'b0, 12'h456, 1'b0, 1'b0, 16'h0000, 16'h1F41};

    reset            = 1'b1;
    bus.vid_rd_en    = 1'b0;
    bus.vid_addr     = '0;
    bus.host_req     = 1'b0;
    bus.host_wr      = 1'b0;
    bus.host_addr    = '0;
    bus.host_wr_data = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst vid_data_valid", bus.vid_data_valid, 0);
    chk("rst host_ack",       bus.host_ack, 0);
    chk("rst host_rd_data",   bus.host_rd_data, 0);
    chk("rst host_starved",   bus.host_starved, 0);
    chk("rst mem_en",         bus.mem_en, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // per-cycle vectors
    for (int i = 0; i < 18; i++) begin
      @(posedge clk); #1;
      bus.vid_rd_en    = vt[i].vid;
      bus.vid_addr     = vt[i].vaddr;
      bus.host_req     = vt[i].req;
      bus.host_wr      = vt[i].wr;
      bus.host_addr    = vt[i].haddr;
      bus.host_wr_data = vt[i].wdata;
      @(negedge clk);
      chk($sformatf("vec%0d mem_en", i),         bus.mem_en, vt[i].e_en);
      chk($sformatf("vec%0d mem_wr", i),         bus.mem_wr, vt[i].e_wr);
      chk($sformatf("vec%0d mem_addr", i),       bus.mem_addr, vt[i].e_addr);
      chk($sformatf("vec%0d host_ack", i),       bus.host_ack, vt[i].e_ack);
      chk($sformatf("vec%0d vid_data_valid", i), bus.vid_data_valid, vt[i].e_vdv);
      chk($sformatf("vec%0d host_rd_data", i),   bus.host_rd_data, vt[i].e_rd);
      chk($sformatf("vec%0d host_starved", i),   bus.host_starved, 0);
      if (vt[i].e_vdv)
        chk($sformatf("vec%0d vid_data", i),     bus.vid_data, vt[i].e_vdata);
      if (vt[i].e_wr)
        chk($sformatf("vec%0d mem_wr_data", i),  bus.mem_wr_data, vt[i].wdata);
    end

    // scanline stress: one fetch per 8 cycles, host back-to-back on its own region
    fork
      begin
        for (int t = 0; t < CHARS_WIDE * FONT_WIDTH; t++) begin
          @(posedge clk); #1;
          bus.vid_rd_en = (t % 8 == 0);
          bus.vid_addr  = 12'h800 + 12'(t / 8);
          @(negedge clk);
          if (t % 8 == 1) begin
            chk($sformatf("scan t%0d vid_data_valid", t), bus.vid_data_valid, 1);
            chk($sformatf("scan t%0d vid_data", t), bus.vid_data, pat(12'h800 + 12'(t / 8)));
          end
        end
        @(posedge clk); #1;
        bus.vid_rd_en = 1'b0;
        vid_done = 1'b1;
      end
      begin
        logic       w;
        logic       hok;
        disp_addr_t a;
        disp_data_t d;
        while (!vid_done) begin
          w = 1'($urandom_range(0, 1));
          a = 12'h500 + 12'($urandom_range(0, 255));
          d = 16'($urandom);
          host_op(w, a, d, hok);
          if (hok) begin
            if (w) shadow[a] = d;
            else chk($sformatf("scan rd %h", a), bus.host_rd_data, shadow[a]);
          end
        end
        host_idle();
      end
    join
    @(negedge clk);
    chk("scan host_starved", bus.host_starved, 0);

    // reset while a read sits in RD_WAIT
    @(posedge clk); #1;
    bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_addr = 12'h456;
    @(posedge clk); #1;
    reset = 1'b1;
    bus.host_wr = 1'b1; bus.host_addr = 12'h300; bus.host_wr_data = 16'hBEEF;
    bus.vid_rd_en = 1'b1; bus.vid_addr = 12'h010;
    @(negedge clk);
    chk("rstrd mem_en=vid", bus.mem_en, 1);
    chk("rstrd mem_wr",     bus.mem_wr, 0);
    chk("rstrd mem_addr",   bus.mem_addr, 12'h010);
    chk("rstrd host_ack",   bus.host_ack, 0);
    chk("rstrd host_rd_data", bus.host_rd_data, 0);
    chk("rstrd vid_data_valid", bus.vid_data_valid, 0);
    @(posedge clk); #1;
    bus.vid_rd_en = 1'b0;
    @(negedge clk);
    chk("rstrd no grant mem_en", bus.mem_en, 0);
    chk("rstrd no grant mem_wr", bus.mem_wr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus.host_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rstrd post c%0d host_ack", c), bus.host_ack, 0);
      chk($sformatf("rstrd post c%0d host_rd_data", c), bus.host_rd_data, 0);
    end
    chk("rstrd ram untouched", ram[12'h300], pat(12'h300));
    host_op(1'b1, 12'h300, 16'hBEEF, ok);
    host_op(1'b0, 12'h300, 16'h0000, ok);
    if (ok) chk("rstrd readback", bus.host_rd_data, 16'hBEEF);
    host_idle();

    // starvation: video held 20 cycles with a host read pending
    @(posedge clk); #1;
    bus.vid_rd_en = 1'b1; bus.vid_addr = 12'h010;
    bus.host_req = 1'b1; bus.host_wr = 1'b0; bus.host_addr = 12'h020;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk($sformatf("starve c%0d host_starved", c), bus.host_starved, (c >= 16) ? 1 : 0);
      chk($sformatf("starve c%0d mem_addr", c), bus.mem_addr, 12'h010);
      chk($sformatf("starve c%0d host_ack", c), bus.host_ack, 0);
    end
    @(posedge clk); #1;
    bus.vid_rd_en = 1'b0;
    @(negedge clk);
    chk("starve grant mem_en",   bus.mem_en, 1);
    chk("starve grant mem_wr",   bus.mem_wr, 0);
    chk("starve grant mem_addr", bus.mem_addr, 12'h020);
    ok = 1'b0;
    for (int k = 0; k < 5 && !ok; k++) begin
      @(negedge clk);
      if (bus.host_ack === 1'b1) ok = 1'b1;
    end
    chk("starve ack seen", ok, 1);
    chk("starve rd_data", bus.host_rd_data, 16'h2222);
    host_idle();
    @(negedge clk);
    chk("starve sticky", bus.host_starved, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("starve cleared by reset", bus.host_starved, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    host_op(1'b1, 12'h301, 16'h1357, ok);
    host_op(1'b0, 12'h301, 16'h0000, ok);
    if (ok) chk("post-reset readback", bus.host_rd_data, 16'h1357);
    host_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
